scan_chain_driver: RTL and testbench

Upstream driver for the scan-wrapper chain. It generates clk_in, data_in, latch_enable_in and scan_select_in for a chain of NUM_DESIGNS wrappers, each 8 bits long, and samples the data_out returned from the chain end.

---
 rtl/scan_chain_driver_if.sv | 21 ++
 rtl/scan_chain_driver.sv | 162 ++++++++++++++++
 tb/tb_scan_chain_driver.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_chain_driver_if.sv
// Request/response handshake between a scan-chain client and scan_chain_driver.
interface scan_chain_driver_if #(
  parameter int unsigned SEL_W = 1
);
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic [7:0]       in_data;
  logic             out_valid;
  logic [7:0]       out_data;

  modport master (
    output in_valid, in_sel, in_data,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_sel, in_data,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/scan_chain_driver.sv
// Drives a chain of 8-bit scan wrappers: shift in, latch, capture, shift out.
module scan_chain_driver #(
  parameter int unsigned NUM_DESIGNS  = 2,
  parameter int unsigned SEL_W        = 1,
  parameter int unsigned CLK_DIV      = 1,
  parameter int unsigned LATCH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  scan_chain_driver_if.slave req,
  output logic               scan_clk_out,
  output logic               scan_data_out,
  output logic               scan_latch_out,
  output logic               scan_select_out,
  input  logic               scan_data_in
);
  localparam int unsigned L     = 8 * NUM_DESIGNS;
  localparam int unsigned BIT_W = (L > 1) ? $clog2(L) : 1;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, SHIFT_IN, LATCH, CAPTURE, SHIFT_OUT} state_t;

  state_t           state, state_n;
  logic             half, half_n;
  logic [DIV_W-1:0] div, div_n;
  logic [BIT_W-1:0] bit_cnt, bit_n;
  logic [LAT_W-1:0] lat, lat_n;
  logic [L-1:0]     frame, frame_n, rx, rx_n, load_frame;
  logic [SEL_W-1:0] sel, sel_n;
  logic [7:0]       slot;
  logic             half_end;

  logic       ready_q, ready_n, valid_q, valid_n;
  logic [7:0] odata_q, odata_n;
  logic       sclk_q, sclk_n, sdata_q, sdata_n, slatch_q, slatch_n, ssel_q, ssel_n;

  // Registers hold the values for the cycle being driven; next-cycle outputs
  // are derived from the next-state values so every output is a flop.
  always_comb begin
    load_frame = '0;
    slot       = '0;
    for (int unsigned k = 0; k < NUM_DESIGNS; k++) begin
      if (req.in_sel == SEL_W'(k)) load_frame[8*k +: 8] = req.in_data;
      if (sel == SEL_W'(k))        slot = rx[8*k +: 8];
    end

    half_end = (div == DIV_W'(CLK_DIV - 1));
    state_n  = state;
    half_n   = half;
    div_n    = div;
    bit_n    = bit_cnt;
    lat_n    = lat;
    frame_n  = frame;
    rx_n     = rx;
    sel_n    = sel;
    valid_n  = 1'b0;
    odata_n  = odata_q;

    case (state)
      IDLE: begin
        if (req.in_valid && ready_q) begin
          state_n = SHIFT_IN;
          half_n  = 1'b0;
          div_n   = '0;
          bit_n   = '0;
          frame_n = load_frame;
          sel_n   = req.in_sel;
        end
      end
      SHIFT_IN, CAPTURE, SHIFT_OUT: begin
        if (state == SHIFT_OUT && !half && half_end) rx_n = {rx[L-2:0], scan_data_in};
        if (!half_end) begin
          div_n = div + 1'b1;
        end else begin
          div_n = '0;
          if (!half) begin
            half_n = 1'b1;
          end else begin
            half_n = 1'b0;
            if (state == CAPTURE) begin
              state_n = SHIFT_OUT;
              bit_n   = '0;
            end else if (bit_cnt != BIT_W'(L - 1)) begin
              bit_n = bit_cnt + 1'b1;
              if (state == SHIFT_IN) frame_n = frame << 1;
            end else if (state == SHIFT_IN) begin
              state_n = LATCH;
              lat_n   = '0;
            end else begin
              state_n = IDLE;
              valid_n = 1'b1;
              odata_n = slot;
            end
          end
        end
      end
      LATCH: begin
        if (lat == LAT_W'(LATCH_CYCLES - 1)) begin
          state_n = CAPTURE;
          half_n  = 1'b0;
          div_n   = '0;
        end else begin
          lat_n = lat + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    ready_n  = (state_n == IDLE);
    sclk_n   = half_n && (state_n == SHIFT_IN || state_n == CAPTURE || state_n == SHIFT_OUT);
    slatch_n = (state_n == LATCH);
    ssel_n   = (state_n == CAPTURE);
    if (state_n == SHIFT_IN)   sdata_n = frame_n[L-1];
    else if (state_n == LATCH) sdata_n = sdata_q;
    else                       sdata_n = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      half     <= 1'b0;
      div      <= '0;
      bit_cnt  <= '0;
      lat      <= '0;
      frame    <= '0;
      rx       <= '0;
      sel      <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      odata_q  <= '0;
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
      slatch_q <= 1'b0;
      ssel_q   <= 1'b0;
    end else begin
      state    <= state_n;
      half     <= half_n;
      div      <= div_n;
      bit_cnt  <= bit_n;
      lat      <= lat_n;
      frame    <= frame_n;
      rx       <= rx_n;
      sel      <= sel_n;
      ready_q  <= ready_n;
      valid_q  <= valid_n;
      odata_q  <= odata_n;
      sclk_q   <= sclk_n;
      sdata_q  <= sdata_n;
      slatch_q <= slatch_n;
      ssel_q   <= ssel_n;
    end
  end

  assign req.in_ready    = ready_q;
  assign req.out_valid   = valid_q;
  assign req.out_data    = odata_q;
  assign scan_clk_out    = sclk_q;
  assign scan_data_out   = sdata_q;
  assign scan_latch_out  = slatch_q;
  assign scan_select_out = ssel_q;
endmodule

// File: tb/tb_scan_chain_driver.sv
// Directed bench for scan_chain_driver with a behavioural wrapper-chain model.
`timescale 1ns/1ps
module tb_scan_chain_driver;
  localparam int unsigned LA = 16;
  localparam logic [LA-1:0] CAP_A = 16'h3CFF;
  localparam logic [LA-1:0] CAP_B = 16'h1234;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  scan_chain_driver_if #(.SEL_W(2)) bus_a ();
  scan_chain_driver_if #(.SEL_W(1)) bus_b ();

  logic sclk_a, sdo_a, slat_a, ssel_a, sdi_a;
  logic sclk_b, sdo_b, slat_b, ssel_b, sdi_b;
  logic [LA-1:0] chain_a = '0;
  logic [LA-1:0] chain_b = '0;
  logic [LA-1:0] latched_a = '0;

  scan_chain_driver #(.NUM_DESIGNS(2), .SEL_W(2), .CLK_DIV(1), .LATCH_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .req(bus_a.slave),
    .scan_clk_out(sclk_a), .scan_data_out(sdo_a), .scan_latch_out(slat_a),
    .scan_select_out(ssel_a), .scan_data_in(sdi_a)
  );

  scan_chain_driver #(.NUM_DESIGNS(2), .SEL_W(1), .CLK_DIV(3), .LATCH_CYCLES(2)) dut_b (
    .clk(clk), .reset(reset), .req(bus_b.slave),
    .scan_clk_out(sclk_b), .scan_data_out(sdo_b), .scan_latch_out(slat_b),
    .scan_select_out(ssel_b), .scan_data_in(sdi_b)
  );

  // Chain model: capture when scan_select is high, else shift toward the chain end.
  assign sdi_a = chain_a[LA-1];
  assign sdi_b = chain_b[LA-1];
  always @(posedge sclk_a) chain_a <= ssel_a ? CAP_A : {chain_a[LA-2:0], sdo_a};
  always @(posedge sclk_b) chain_b <= ssel_b ? CAP_B : {chain_b[LA-2:0], sdo_b};
  always @(posedge clk) if (slat_a) latched_a <= chain_a;

  typedef struct {
    int unsigned   lat;
    logic [LA-1:0] bits;
    int unsigned   nrise;
    int unsigned   nlatch;
    int unsigned   nsel;
    int unsigned   sel_first;
    int unsigned   nvalid;
    logic [7:0]    odata;
  } meas_t;

  task automatic wait_ready_a();
    int unsigned t = 0;
    while (bus_a.in_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
  endtask

  // Issues one request on dut_a and records what the scan pins did, cycle by cycle.
  task automatic run_a(input logic [1:0] sel, input logic [7:0] data, output meas_t m);
    logic prev = 1'b0;
    m.lat = 0; m.bits = '0; m.nrise = 0; m.nlatch = 0;
    m.nsel = 0; m.sel_first = 0; m.nvalid = 0; m.odata = '0;
    wait_ready_a();
    bus_a.in_sel = sel;
    bus_a.in_data = data;
    bus_a.in_valid = 1'b1;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    for (int unsigned c = 1; c <= 300; c++) begin
      if (sclk_a && !prev) begin
        if (m.nrise < LA) m.bits = {m.bits[LA-2:0], sdo_a};
        m.nrise++;
      end
      prev = sclk_a;
      if (slat_a) m.nlatch++;
      if (ssel_a) begin
        if (m.nsel == 0) m.sel_first = c;
        m.nsel++;
      end
      if (bus_a.out_valid) begin
        if (m.nvalid == 0) begin
          m.lat = c;
          m.odata = bus_a.out_data;
        end
        m.nvalid++;
      end
      if (m.lat != 0 && c >= m.lat + 2) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [13:0] obs;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    obs = {bus_a.in_ready, bus_a.out_valid, sclk_a, sdo_a, slat_a, ssel_a, bus_a.out_data};
    n_checks++;
    if (obs !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_outputs_a: got %h expected 0000", obs);
    end
    n_checks++;
    if (bus_b.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_b: got %b expected 0", bus_b.in_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus_a.in_ready, bus_b.in_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b expected 11", {bus_a.in_ready, bus_b.in_ready});
    end
  endtask

  task automatic test_shift_in();
    meas_t m;
    run_a(2'd1, 8'hA5, m);
    n_checks++;
    if (m.bits !== 16'hA500) begin
      n_fail++;
      $display("FAIL shift_in_bits: got %h expected a500", m.bits);
    end
    n_checks++;
    if (latched_a !== 16'hA500) begin
      n_fail++;
      $display("FAIL latched_frame: got %h expected a500", latched_a);
    end
    n_checks++;
    if (m.nlatch !== 2) begin
      n_fail++;
      $display("FAIL latch_cycles: got %0d expected 2", m.nlatch);
    end
    n_checks++;
    if (m.lat !== 69 || m.nvalid !== 1) begin
      n_fail++;
      $display("FAIL latency_default: got %0d (pulses %0d) expected 69 (1)", m.lat, m.nvalid);
    end
    n_checks++;
    if (m.sel_first !== 35 || m.nsel !== 2) begin
      n_fail++;
      $display("FAIL select_window: got start %0d len %0d expected 35 2", m.sel_first, m.nsel);
    end
    n_checks++;
    if (m.nrise !== 33) begin
      n_fail++;
      $display("FAIL scan_clk_rises: got %0d expected 33", m.nrise);
    end
    n_checks++;
    if (m.odata !== 8'h3C) begin
      n_fail++;
      $display("FAIL out_data_sel1: got %h expected 3c", m.odata);
    end
  endtask

  task automatic test_capture_return();
    meas_t m;
    run_a(2'd0, 8'h11, m);
    n_checks++;
    if (m.odata !== 8'hFF || m.lat !== 69) begin
      n_fail++;
      $display("FAIL out_data_sel0: got %h at %0d expected ff at 69", m.odata, m.lat);
    end
    n_checks++;
    if (m.bits !== 16'h0011) begin
      n_fail++;
      $display("FAIL shift_in_sel0: got %h expected 0011", m.bits);
    end
    n_checks++;
    if (bus_a.out_data !== 8'hFF) begin
      n_fail++;
      $display("FAIL out_data_hold: got %h expected ff", bus_a.out_data);
    end
  endtask

  task automatic test_out_of_range();
    meas_t m;
    run_a(2'd3, 8'h77, m);
    n_checks++;
    if (m.bits !== 16'h0000 || latched_a !== 16'h0000) begin
      n_fail++;
      $display("FAIL oor_frame: got bits %h latched %h expected 0000", m.bits, latched_a);
    end
    n_checks++;
    if (m.odata !== 8'h00 || m.lat !== 69) begin
      n_fail++;
      $display("FAIL oor_out: got %h at %0d expected 00 at 69", m.odata, m.lat);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned acc[$];
    int unsigned vld[$];
    logic [7:0] od[$];
    int unsigned busy_ready = 0;
    int unsigned sel_bad = 0;
    wait_ready_a();
    bus_a.in_sel = 2'd0;
    bus_a.in_data = 8'h5A;
    bus_a.in_valid = 1'b1;
    for (int unsigned c = 0; c <= 160; c++) begin
      if (c == 1) begin
        bus_a.in_sel = 2'd1;
        bus_a.in_data = 8'hC3;
      end
      if (acc.size() == 2 && bus_a.in_valid) bus_a.in_valid = 1'b0;
      if (bus_a.in_valid && bus_a.in_ready) acc.push_back(c);
      if (bus_a.out_valid) begin
        vld.push_back(c);
        od.push_back(bus_a.out_data);
      end
      if (bus_a.in_ready && c >= 1 && c < 69) busy_ready++;
      if (ssel_a && !((c >= 35 && c <= 36) || (c >= 104 && c <= 105))) sel_bad++;
      @(negedge clk);
    end
    bus_a.in_valid = 1'b0;
    n_checks++;
    if (acc.size() != 2 || acc[0] != 0 || acc[1] != 69) begin
      n_fail++;
      $display("FAIL b2b_accepts: got %0d accepts, second at %0d expected 2 at 69",
               acc.size(), (acc.size() > 1) ? acc[1] : 0);
    end
    n_checks++;
    if (vld.size() != 2 || vld[0] != 69 || vld[1] != 138) begin
      n_fail++;
      $display("FAIL b2b_valids: got %0d pulses, first %0d expected 2 at 69/138",
               vld.size(), (vld.size() > 0) ? vld[0] : 0);
    end
    n_checks++;
    if (od.size() != 2 || od[0] !== 8'hFF || od[1] !== 8'h3C) begin
      n_fail++;
      $display("FAIL b2b_data: got %0d results first %h expected ff then 3c",
               od.size(), (od.size() > 0) ? od[0] : 8'h00);
    end
    n_checks++;
    if (busy_ready != 0 || sel_bad != 0) begin
      n_fail++;
      $display("FAIL b2b_busy: got ready %0d stray select %0d expected 0 0", busy_ready, sel_bad);
    end
  endtask

  task automatic test_reset_mid();
    int unsigned nv = 0;
    logic [13:0] obs;
    meas_t m;
    wait_ready_a();
    bus_a.in_sel = 2'd1;
    bus_a.in_data = 8'h81;
    bus_a.in_valid = 1'b1;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    repeat (49) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    obs = {bus_a.in_ready, bus_a.out_valid, sclk_a, sdo_a, slat_a, ssel_a, bus_a.out_data};
    n_checks++;
    if (obs !== 14'h0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %h expected 0000", obs);
    end
    reset = 1'b0;
    for (int unsigned c = 0; c < 80; c++) begin
      @(negedge clk);
      if (bus_a.out_valid) nv++;
    end
    n_checks++;
    if (nv != 0) begin
      n_fail++;
      $display("FAIL mid_reset_abort: got %0d out_valid pulses expected 0", nv);
    end
    run_a(2'd1, 8'h42, m);
    n_checks++;
    if (m.odata !== 8'h3C || m.lat !== 69 || m.bits !== 16'h4200) begin
      n_fail++;
      $display("FAIL after_reset_txn: got %h at %0d bits %h expected 3c at 69 bits 4200",
               m.odata, m.lat, m.bits);
    end
  endtask

  task automatic test_clk_div();
    int unsigned t = 0;
    int unsigned run = 0;
    int unsigned nruns = 0;
    int unsigned bad_runs = 0;
    int unsigned lat = 0;
    int unsigned nrise = 0;
    logic [LA-1:0] bits = '0;
    logic [7:0] odata = '0;
    logic prev = 1'b0;
    while (bus_b.in_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    bus_b.in_sel = 1'b0;
    bus_b.in_data = 8'h96;
    bus_b.in_valid = 1'b1;
    @(negedge clk);
    bus_b.in_valid = 1'b0;
    for (int unsigned c = 1; c <= 400; c++) begin
      if (c > 1 && sclk_b !== prev) begin
        nruns++;
        if (run != 3) bad_runs++;
        run = 0;
        if (sclk_b && nrise < LA) bits = {bits[LA-2:0], sdo_b};
        if (sclk_b) nrise++;
      end
      if (!slat_b) run++;
      prev = sclk_b;
      if (bus_b.out_valid && lat == 0) begin
        lat = c;
        odata = bus_b.out_data;
      end
      if (lat != 0) break;
      @(negedge clk);
    end
    n_checks++;
    if (lat != 201) begin
      n_fail++;
      $display("FAIL latency_div3: got %0d expected 201", lat);
    end
    n_checks++;
    if (nruns != 66 || bad_runs != 0) begin
      n_fail++;
      $display("FAIL half_period_div3: got %0d runs %0d wrong expected 66 0", nruns, bad_runs);
    end
    n_checks++;
    if (bits !== 16'h0096) begin
      n_fail++;
      $display("FAIL shift_in_div3: got %h expected 0096", bits);
    end
    n_checks++;
    if (odata !== 8'h34) begin
      n_fail++;
      $display("FAIL out_data_div3: got %h expected 34", odata);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus_a.in_valid = 1'b0;
    bus_a.in_sel = '0;
    bus_a.in_data = '0;
    bus_b.in_valid = 1'b0;
    bus_b.in_sel = '0;
    bus_b.in_data = '0;
    test_reset();
    test_shift_in();
    test_capture_return();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    test_clk_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
